mining_job_sequencer: RTL and testbench

- Upstream feeder for mining_pipeline: accepts one mining job (81-trit-packed header, nonce start, nonce count) over a valid/ready handshake.
- Drives the pipeline's opcode/operand/valid_opcode/start_mine inputs one nonce at a time.
- Watches match_found during a fixed result window after each issue and returns the winning nonce, or "not found", on a result handshake.

---
 rtl/mining_pkg.sv | 21 ++
 rtl/mining_nonce_counter.sv | 52 +++++
 rtl/mining_job_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_mining_job_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mining_pkg.sv
// Shared definitions for the mining job sequencer and its pipeline neighbours.
// Holds datapath widths, pipeline opcodes and the sequencer state encoding.
package mining_pkg;

    localparam int T81_W       = 81;
    localparam int NONCE_W_DEF = 32;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_MINE     = 8'h01;
    localparam logic [7:0] OP_LOAD_HDR = 8'h02;
    localparam logic [7:0] OP_FLUSH    = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } seq_state_t;

endpackage

// File: rtl/mining_nonce_counter.sv
// Nonce bookkeeping for one mining job: current nonce (wraps modulo 2^NONCE_W),
// nonces still to try, and nonces whose result window has closed or matched.
// last is high while the current nonce is the final one of the job.
module mining_nonce_counter
    import mining_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [NONCE_W-1:0] load_nonce,
    input  logic [NONCE_W-1:0] load_count,
    input  logic               step,
    input  logic               inc_tried,
    output logic [NONCE_W-1:0] nonce,
    output logic [NONCE_W-1:0] nonce_inc,
    output logic [NONCE_W-1:0] tried,
    output logic [NONCE_W-1:0] tried_inc,
    output logic               last
);

    localparam logic [NONCE_W-1:0] ONE = {{(NONCE_W-1){1'b0}}, 1'b1};

    logic [NONCE_W-1:0] remaining;

    assign nonce_inc = nonce + ONE;
    assign tried_inc = tried + ONE;
    assign last      = (remaining == ONE);

    // Load on job accept, otherwise advance nonce/remaining and count tried nonces.
    always_ff @(posedge clk) begin
        if (!rst) begin
            nonce     <= '0;
            remaining <= '0;
            tried     <= '0;
        end else if (load) begin
            nonce     <= load_nonce;
            remaining <= load_count;
            tried     <= '0;
        end else begin
            if (step) begin
                nonce     <= nonce_inc;
                remaining <= remaining - ONE;
            end
            if (inc_tried) begin
                tried <= tried_inc;
            end
        end
    end

endmodule

// File: rtl/mining_job_sequencer.sv
// Feeds one mining job into mining_pipeline a nonce at a time, watches
// match_found for RESULT_WAIT cycles after each issue, and reports the
// winning nonce (or not-found) on a result handshake.
// Optional build macro MINING_SEQ_STATS_EN adds saturating lifetime counters
// stat_nonces / stat_matches.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | job_ready high, waiting for a job
// ST_START  | start_mine pulse for the accepted job
// ST_ISSUE  | valid_opcode pulse carrying the current nonce
// ST_WAIT   | RESULT_WAIT-cycle window sampling match_found
// ST_RESULT | res_valid high, res_* held until res_ready
module mining_job_sequencer
    import mining_pkg::*;
#(
    parameter int RESULT_WAIT = 4,
    parameter int NONCE_W     = NONCE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [T81_W-1:0]   job_header,
    input  logic [NONCE_W-1:0] job_nonce_start,
    input  logic [NONCE_W-1:0] job_nonce_count,
    input  logic               abort,
    output logic [7:0]         opcode,
    output logic [T81_W-1:0]   operand,
    output logic               valid_opcode,
    output logic               start_mine,
    input  logic               match_found,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_found,
    output logic [NONCE_W-1:0] res_nonce,
    output logic [NONCE_W-1:0] res_tried,
`ifdef MINING_SEQ_STATS_EN
    output logic [47:0]        stat_nonces,
    output logic [15:0]        stat_matches,
`endif
    output logic               busy
);

    localparam logic [7:0] WIN_LOAD = 8'(RESULT_WAIT);

    seq_state_t                state;
    logic [7:0]                window;
    logic [T81_W-NONCE_W-1:0]  hdr_q;

    logic                      accept;
    logic                      wait_match;
    logic                      wait_abort;
    logic                      wait_expire;
    logic                      cnt_step;
    logic                      cnt_inc_tried;
    logic [NONCE_W-1:0]        nonce;
    logic [NONCE_W-1:0]        nonce_inc;
    logic [NONCE_W-1:0]        tried;
    logic [NONCE_W-1:0]        tried_inc;
    logic                      last;

    // The low header bits are replaced by the nonce on the operand bus.
    logic                      unused_hdr_low;
    assign unused_hdr_low = ^job_header[NONCE_W-1:0];

    // Match outranks abort, abort outranks window expiry.
    assign accept        = (state == ST_IDLE) && job_valid && job_ready;
    assign wait_match    = (state == ST_WAIT) && match_found;
    assign wait_abort    = (state == ST_WAIT) && !match_found && abort;
    assign wait_expire   = (state == ST_WAIT) && !match_found && !abort && (window == 8'd1);
    assign cnt_inc_tried = wait_match || wait_expire;
    assign cnt_step      = wait_expire && !last;

    mining_nonce_counter #(
        .NONCE_W (NONCE_W)
    ) u_nonce_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_nonce (job_nonce_start),
        .load_count (job_nonce_count),
        .step       (cnt_step),
        .inc_tried  (cnt_inc_tried),
        .nonce      (nonce),
        .nonce_inc  (nonce_inc),
        .tried      (tried),
        .tried_inc  (tried_inc),
        .last       (last)
    );

    // Sequencer FSM with all handshake and pipeline outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            window       <= '0;
            hdr_q        <= '0;
            job_ready    <= 1'b0;
            busy         <= 1'b0;
            opcode       <= '0;
            operand      <= '0;
            valid_opcode <= 1'b0;
            start_mine   <= 1'b0;
            res_valid    <= 1'b0;
            res_found    <= 1'b0;
            res_nonce    <= '0;
            res_tried    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    job_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (accept) begin
                        job_ready <= 1'b0;
                        busy      <= 1'b1;
                        hdr_q     <= job_header[T81_W-1:NONCE_W];
                        if (job_nonce_count == '0) begin
                            state     <= ST_RESULT;
                            res_valid <= 1'b1;
                            res_found <= 1'b0;
                            res_nonce <= job_nonce_start;
                            res_tried <= '0;
                        end else begin
                            state      <= ST_START;
                            start_mine <= 1'b1;
                        end
                    end
                end

                ST_START: begin
                    start_mine <= 1'b0;
                    if (abort) begin
                        state     <= ST_RESULT;
                        res_valid <= 1'b1;
                        res_found <= 1'b0;
                        res_nonce <= nonce;
                        res_tried <= tried;
                    end else begin
                        state        <= ST_ISSUE;
                        valid_opcode <= 1'b1;
                        opcode       <= OP_MINE;
                        operand      <= {hdr_q, nonce};
                    end
                end

                ST_ISSUE: begin
                    valid_opcode <= 1'b0;
                    if (abort) begin
                        state     <= ST_RESULT;
                        res_valid <= 1'b1;
                        res_found <= 1'b0;
                        res_nonce <= nonce;
                        res_tried <= tried;
                    end else begin
                        state  <= ST_WAIT;
                        window <= WIN_LOAD;
                    end
                end

                ST_WAIT: begin
                    if (wait_match) begin
                        state     <= ST_RESULT;
                        res_valid <= 1'b1;
                        res_found <= 1'b1;
                        res_nonce <= nonce;
                        res_tried <= tried_inc;
                    end else if (wait_abort) begin
                        state     <= ST_RESULT;
                        res_valid <= 1'b1;
                        res_found <= 1'b0;
                        res_nonce <= nonce;
                        res_tried <= tried;
                    end else if (wait_expire) begin
                        if (last) begin
                            state     <= ST_RESULT;
                            res_valid <= 1'b1;
                            res_found <= 1'b0;
                            res_nonce <= nonce;
                            res_tried <= tried_inc;
                        end else begin
                            state        <= ST_ISSUE;
                            valid_opcode <= 1'b1;
                            opcode       <= OP_MINE;
                            operand      <= {hdr_q, nonce_inc};
                        end
                    end else begin
                        window <= window - 8'd1;
                    end
                end

                ST_RESULT: begin
                    if (res_ready) begin
                        state     <= ST_IDLE;
                        res_valid <= 1'b0;
                        job_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MINING_SEQ_STATS_EN
    // Lifetime counters: every closed or matched window, and every found job.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_nonces  <= '0;
            stat_matches <= '0;
        end else begin
            if (cnt_inc_tried && (stat_nonces != '1)) begin
                stat_nonces <= stat_nonces + 48'd1;
            end
            if (wait_match && (stat_matches != '1)) begin
                stat_matches <= stat_matches + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mining_job_sequencer.sv
// Directed bench for mining_job_sequencer with RESULT_WAIT=4, NONCE_W=32.
module tb_mining_job_sequencer;
    import mining_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [80:0]   job_header = '0;
    logic [31:0]   job_nonce_start = '0;
    logic [31:0]   job_nonce_count = '0;
    logic          abort = 1'b0;
    logic [7:0]    opcode;
    logic [80:0]   operand;
    logic          valid_opcode;
    logic          start_mine;
    logic          match_found = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_found;
    logic [31:0]   res_nonce;
    logic [31:0]   res_tried;
    logic          busy;
`ifdef MINING_SEQ_STATS_EN
    logic [47:0]   stat_nonces;
    logic [15:0]   stat_matches;
`endif

    always #5 clk = ~clk;

    mining_job_sequencer #(.RESULT_WAIT(4), .NONCE_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_header      (job_header),
        .job_nonce_start (job_nonce_start),
        .job_nonce_count (job_nonce_count),
        .abort           (abort),
        .opcode          (opcode),
        .operand         (operand),
        .valid_opcode    (valid_opcode),
        .start_mine      (start_mine),
        .match_found     (match_found),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_found       (res_found),
        .res_nonce       (res_nonce),
        .res_tried       (res_tried),
`ifdef MINING_SEQ_STATS_EN
        .stat_nonces     (stat_nonces),
        .stat_matches    (stat_matches),
`endif
        .busy            (busy)
    );

    localparam logic [80:0] HDR = 81'h1_2345_6789_ABCD_EF01_2345;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Observations from the most recent run_job.
    int          n_start;
    int          n_issue;
    int          cyc_done;
    logic        timed_out;
    logic [31:0] iss_nonce [0:7];
    int          iss_time  [0:7];
    logic [7:0]  iss_op    [0:7];
    logic [48:0] iss_hdr   [0:7];
    logic        r_found;
    logic [31:0] r_nonce;
    logic [31:0] r_tried;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one job and steps until res_valid, pulsing match_found / abort in
    // WAIT cycle wcyc (1-based) after issue number idx (1-based); idx 0 = never.
    task automatic run_job(input logic [80:0] hdr, input logic [31:0] st, input logic [31:0] cnt,
                           input int m_idx, input int m_wcyc, input int a_idx, input int a_wcyc);
        int cyc;
        int last_t;
        n_start   = 0;
        n_issue   = 0;
        timed_out = 1'b0;
        last_t    = -100;
        job_header      = hdr;
        job_nonce_start = st;
        job_nonce_count = cnt;
        job_valid       = 1'b1;
        cyc = 0;
        while (!job_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!job_ready) timed_out = 1'b1;
        tick();
        job_valid = 1'b0;
        cyc = 0;
        while (!res_valid && cyc < 200) begin
            if (start_mine) n_start++;
            if (valid_opcode) begin
                if (n_issue < 8) begin
                    iss_nonce[n_issue] = operand[31:0];
                    iss_time[n_issue]  = cyc;
                    iss_op[n_issue]    = opcode;
                    iss_hdr[n_issue]   = operand[80:32];
                end
                n_issue++;
                last_t = cyc;
            end
            match_found = (n_issue == m_idx) && (cyc == last_t + m_wcyc);
            abort       = (n_issue == a_idx) && (cyc == last_t + a_wcyc);
            tick();
            cyc++;
        end
        match_found = 1'b0;
        abort       = 1'b0;
        if (!res_valid) timed_out = 1'b1;
        cyc_done = cyc;
        r_found  = res_found;
        r_nonce  = res_nonce;
        r_tried  = res_tried;
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        check_cnt++;
        if ({job_ready, busy, valid_opcode, start_mine, res_valid, res_found} !== 6'b0) $display("FAIL reset_flags got %b want 000000", {job_ready, busy, valid_opcode, start_mine, res_valid, res_found});
        else pass_cnt++;
        check_cnt++;
        if ({opcode, operand} !== 89'b0) $display("FAIL reset_bus got opcode=%h operand=%h want 0", opcode, operand);
        else pass_cnt++;
        check_cnt++;
        if ({res_nonce, res_tried} !== 64'b0) $display("FAIL reset_res got nonce=%h tried=%h want 0", res_nonce, res_tried);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        check_cnt++;
        if (job_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", job_ready);
        else pass_cnt++;
    endtask

    task automatic test_no_match();
        run_job(HDR, 32'h10, 32'd3, 0, 0, 0, 0);
        check_cnt++;
        if (timed_out !== 1'b0) $display("FAIL nomatch_timeout got %b want 0", timed_out);
        else pass_cnt++;
        check_cnt++;
        if (n_start !== 1 || n_issue !== 3) $display("FAIL nomatch_pulses got start=%0d issue=%0d want 1 3", n_start, n_issue);
        else pass_cnt++;
        check_cnt++;
        if (iss_nonce[0] !== 32'h10 || iss_nonce[1] !== 32'h11 || iss_nonce[2] !== 32'h12)
            $display("FAIL nomatch_nonces got %h %h %h want 10 11 12", iss_nonce[0], iss_nonce[1], iss_nonce[2]);
        else pass_cnt++;
        check_cnt++;
        if (iss_time[1] - iss_time[0] !== 5 || iss_time[2] - iss_time[1] !== 5)
            $display("FAIL nomatch_cadence got %0d %0d want 5 5", iss_time[1] - iss_time[0], iss_time[2] - iss_time[1]);
        else pass_cnt++;
        check_cnt++;
        if (iss_op[0] !== 8'h01 || iss_hdr[0] !== HDR[80:32]) $display("FAIL nomatch_opcode_hdr got op=%h hdr=%h want 01 %h", iss_op[0], iss_hdr[0], HDR[80:32]);
        else pass_cnt++;
        check_cnt++;
        if ({r_found, r_nonce, r_tried} !== {1'b0, 32'h12, 32'd3}) $display("FAIL nomatch_result got f=%b n=%h t=%0d want 0 12 3", r_found, r_nonce, r_tried);
        else pass_cnt++;
        accept_result();
        check_cnt++;
        if (res_valid !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0) $display("FAIL nomatch_release got v=%b r=%b b=%b want 0 1 0", res_valid, job_ready, busy);
        else pass_cnt++;
    endtask

    task automatic test_match();
        run_job(HDR, 32'h10, 32'd3, 2, 3, 0, 0);
        check_cnt++;
        if (timed_out !== 1'b0 || n_issue !== 2) $display("FAIL match_issues got to=%b issue=%0d want 0 2", timed_out, n_issue);
        else pass_cnt++;
        check_cnt++;
        if ({r_found, r_nonce, r_tried} !== {1'b1, 32'h11, 32'd2}) $display("FAIL match_result got f=%b n=%h t=%0d want 1 11 2", r_found, r_nonce, r_tried);
        else pass_cnt++;
        accept_result();
    endtask

    task automatic test_wrap();
        run_job(HDR, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 0);
        check_cnt++;
        if (timed_out !== 1'b0 || n_issue !== 3) $display("FAIL wrap_issues got to=%b issue=%0d want 0 3", timed_out, n_issue);
        else pass_cnt++;
        check_cnt++;
        if (iss_nonce[0] !== 32'hFFFF_FFFE || iss_nonce[1] !== 32'hFFFF_FFFF || iss_nonce[2] !== 32'h0)
            $display("FAIL wrap_nonces got %h %h %h want fffffffe ffffffff 0", iss_nonce[0], iss_nonce[1], iss_nonce[2]);
        else pass_cnt++;
        check_cnt++;
        if ({r_found, r_nonce, r_tried} !== {1'b0, 32'h0, 32'd3}) $display("FAIL wrap_result got f=%b n=%h t=%0d want 0 0 3", r_found, r_nonce, r_tried);
        else pass_cnt++;
        accept_result();
    endtask

    task automatic test_count_zero();
        run_job(HDR, 32'h77, 32'd0, 0, 0, 0, 0);
        check_cnt++;
        if (timed_out !== 1'b0 || cyc_done > 1) $display("FAIL zero_latency got to=%b cyc=%0d want 0 <=1", timed_out, cyc_done);
        else pass_cnt++;
        check_cnt++;
        if (n_start !== 0 || n_issue !== 0 || start_mine !== 1'b0) $display("FAIL zero_pulses got start=%0d issue=%0d want 0 0", n_start, n_issue);
        else pass_cnt++;
        check_cnt++;
        if ({r_found, r_nonce, r_tried} !== {1'b0, 32'h77, 32'd0}) $display("FAIL zero_result got f=%b n=%h t=%0d want 0 77 0", r_found, r_nonce, r_tried);
        else pass_cnt++;
        accept_result();
    endtask

    task automatic test_abort();
        run_job(HDR, 32'h10, 32'd3, 0, 0, 2, 2);
        check_cnt++;
        if (timed_out !== 1'b0 || n_issue !== 2) $display("FAIL abort_issues got to=%b issue=%0d want 0 2", timed_out, n_issue);
        else pass_cnt++;
        check_cnt++;
        if ({r_found, r_nonce, r_tried} !== {1'b0, 32'h11, 32'd1}) $display("FAIL abort_result got f=%b n=%h t=%0d want 0 11 1", r_found, r_nonce, r_tried);
        else pass_cnt++;
        accept_result();
        run_job(HDR, 32'h10, 32'd3, 2, 2, 2, 2);
        check_cnt++;
        if ({r_found, r_nonce, r_tried} !== {1'b1, 32'h11, 32'd2}) $display("FAIL abort_vs_match got f=%b n=%h t=%0d want 1 11 2", r_found, r_nonce, r_tried);
        else pass_cnt++;
        accept_result();
    endtask

    task automatic test_back_to_back_stall();
        logic stable;
        run_job(HDR, 32'h55, 32'd1, 0, 0, 0, 0);
        check_cnt++;
        if ({r_found, r_nonce, r_tried} !== {1'b0, 32'h55, 32'd1}) $display("FAIL stall_result got f=%b n=%h t=%0d want 0 55 1", r_found, r_nonce, r_tried);
        else pass_cnt++;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            abort       = i[0];
            match_found = ~i[0];
            tick();
            if (res_valid !== 1'b1 || res_found !== 1'b0 || res_nonce !== 32'h55 || res_tried !== 32'd1 || job_ready !== 1'b0)
                stable = 1'b0;
        end
        abort       = 1'b0;
        match_found = 1'b0;
        check_cnt++;
        if (stable !== 1'b1) $display("FAIL stall_hold got stable=%b want 1", stable);
        else pass_cnt++;
        accept_result();
        check_cnt++;
        if (res_valid !== 1'b0 || job_ready !== 1'b1) $display("FAIL stall_release got v=%b r=%b want 0 1", res_valid, job_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_job();
        logic quiet;
        job_header      = HDR;
        job_nonce_start = 32'h10;
        job_nonce_count = 32'd3;
        job_valid       = 1'b1;
        tick();
        job_valid = 1'b0;
        tick();
        tick();
        tick();
        check_cnt++;
        if (busy !== 1'b1 || opcode !== 8'h01) $display("FAIL midrst_prestate got busy=%b op=%h want 1 01", busy, opcode);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        check_cnt++;
        if ({job_ready, busy, valid_opcode, start_mine, res_valid, res_found, opcode, operand, res_nonce, res_tried} !== '0)
            $display("FAIL midrst_zero got ready=%b busy=%b op=%h operand=%h", job_ready, busy, opcode, operand);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        check_cnt++;
        if (job_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", job_ready);
        else pass_cnt++;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (res_valid !== 1'b0 || valid_opcode !== 1'b0) quiet = 1'b0;
        end
        check_cnt++;
        if (quiet !== 1'b1) $display("FAIL midrst_quiet got quiet=%b want 1", quiet);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_no_match();
        test_match();
        test_wrap();
        test_count_zero();
        test_abort();
        test_back_to_back_stall();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
